// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter sharing one SDRAM port between video fetch, download DMA and Z80 CPU.
// Optional per-requester grant counters are enabled by defining ARB_STATS_EN.
module sdram_slot_arbiter #(
    parameter int LAT        = 4,
    parameter int MAX_STARVE = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        clkref,
`ifdef ARB_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_vid,
    output logic [15:0] stat_dma,
    output logic [15:0] stat_cpu,
`endif
    input  logic        vid_req,
    input  logic [22:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_data,
    input  logic        dma_req,
    input  logic [22:0] dma_addr,
    input  logic [7:0]  dma_din,
    output logic        dma_ack,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic        sd_oe,
    output logic        sd_we,
    output logic [22:0] sd_addr,
    output logic [7:0]  sd_din,
    input  logic [15:0] sd_dout
);

    localparam int              STW        = $clog2(MAX_STARVE + 1);
    localparam logic [STW-1:0]  STARVE_MAX = STW'(MAX_STARVE);
    localparam logic [3:0]      WAIT_INIT  = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_DMA, SRC_CPU} src_t;

    state_t         state_q, state_d;
    src_t           src_q, src_d;
    src_t           pick;
    logic [3:0]     cnt_q, cnt_d;
    logic [STW-1:0] starve_q, starve_d;
    logic           oe_q, oe_d;
    logic           we_q, we_d;
    logic [22:0]    addr_q, addr_d;
    logic [7:0]     din_q, din_d;
    logic           vid_ack_q, vid_ack_d;
    logic           dma_ack_q, dma_ack_d;
    logic           cpu_ack_q, cpu_ack_d;
    logic [15:0]    vid_data_q, vid_data_d;
    logic [7:0]     cpu_dout_q, cpu_dout_d;
    logic           cpu_req;
    logic           cpu_forced;
    logic           grant;

    assign cpu_req    = cpu_rd | cpu_wr;
    assign cpu_forced = cpu_req && (starve_q == STARVE_MAX);

    // A starved CPU overrides the normal video > DMA > CPU order.
    always_comb begin
        pick = SRC_NONE;
        if (cpu_forced)   pick = SRC_CPU;
        else if (vid_req) pick = SRC_VID;
        else if (dma_req) pick = SRC_DMA;
        else if (cpu_req) pick = SRC_CPU;
    end

    // clkref outside IDLE is simply dropped; slots are never queued.
    assign grant = (state_q == IDLE) && clkref && (pick != SRC_NONE);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        oe_d       = oe_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        vid_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        vid_data_d = vid_data_q;
        cpu_dout_d = cpu_dout_q;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    src_d   = pick;
                    unique case (pick)
                        SRC_VID: begin
                            oe_d   = 1'b1;
                            we_d   = 1'b0;
                            addr_d = vid_addr;
                            din_d  = 8'h00;
                        end
                        SRC_DMA: begin
                            oe_d   = 1'b0;
                            we_d   = 1'b1;
                            addr_d = dma_addr;
                            din_d  = dma_din;
                        end
                        SRC_CPU: begin
                            // Simultaneous rd and wr resolves to a write.
                            oe_d   = ~cpu_wr;
                            we_d   = cpu_wr;
                            addr_d = cpu_addr;
                            din_d  = cpu_wr ? cpu_din : 8'h00;
                        end
                        default: begin
                            oe_d = 1'b0;
                            we_d = 1'b0;
                        end
                    endcase
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = WAIT_INIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    unique case (src_q)
                        SRC_VID: begin
                            vid_ack_d  = 1'b1;
                            vid_data_d = sd_dout;
                        end
                        SRC_DMA: dma_ack_d = 1'b1;
                        SRC_CPU: begin
                            cpu_ack_d = 1'b1;
                            if (!we_q)
                                cpu_dout_d = addr_q[0] ? sd_dout[15:8] : sd_dout[7:0];
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                src_d   = SRC_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!cpu_req)
            starve_d = '0;
        else if (grant) begin
            if (pick == SRC_CPU)
                starve_d = '0;
            else if (starve_q != STARVE_MAX)
                starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            src_q      <= SRC_NONE;
            cnt_q      <= 4'd0;
            starve_q   <= '0;
            oe_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 23'd0;
            din_q      <= 8'd0;
            vid_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            vid_data_q <= 16'd0;
            cpu_dout_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            vid_ack_q  <= vid_ack_d;
            dma_ack_q  <= dma_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_data_q <= vid_data_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    assign sd_oe    = oe_q;
    assign sd_we    = we_q;
    assign sd_addr  = addr_q;
    assign sd_din   = din_q;
    assign vid_ack  = vid_ack_q;
    assign dma_ack  = dma_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign vid_data = vid_data_q;
    assign cpu_dout = cpu_dout_q;

`ifdef ARB_STATS_EN
    logic [2:0]  grant_vec;
    logic [15:0] stat_q [3];
    logic [15:0] stat_d [3];

    assign grant_vec = {grant && (pick == SRC_CPU),
                        grant && (pick == SRC_DMA),
                        grant && (pick == SRC_VID)};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stat
            // Clear wins over a coincident grant; counters saturate.
            always_comb begin
                stat_d[gi] = stat_q[gi];
                if (stat_clr)
                    stat_d[gi] = 16'd0;
                else if (grant_vec[gi] && (stat_q[gi] != 16'hFFFF))
                    stat_d[gi] = stat_q[gi] + 16'd1;
            end

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n)
                    stat_q[gi] <= 16'd0;
                else
                    stat_q[gi] <= stat_d[gi];
            end
        end
    endgenerate

    assign stat_vid = stat_q[0];
    assign stat_dma = stat_q[1];
    assign stat_cpu = stat_q[2];
`endif

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed self-checking bench for sdram_slot_arbiter (LAT=4 main instance, LAT=14 for the missed-slot case).
module tb_sdram_slot_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        clkref;
    logic        vid_req, dma_req, cpu_rd, cpu_wr;
    logic [22:0] vid_addr, dma_addr, cpu_addr;
    logic [7:0]  dma_din, cpu_din;
    logic [15:0] sd_dout;

    logic        vid_ack, dma_ack, cpu_ack, sd_oe, sd_we;
    logic [15:0] vid_data;
    logic [7:0]  cpu_dout, sd_din;
    logic [22:0] sd_addr;

    logic        l_vid_ack, l_dma_ack, l_cpu_ack, l_sd_oe, l_sd_we;
    logic [15:0] l_vid_data;
    logic [7:0]  l_cpu_dout, l_sd_din;
    logic [22:0] l_sd_addr;

`ifdef ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_vid, stat_dma, stat_cpu;
    logic [15:0] l_stat_vid, l_stat_dma, l_stat_cpu;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    sdram_slot_arbiter #(.LAT(4), .MAX_STARVE(3)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .clkref(clkref),
`ifdef ARB_STATS_EN
        .stat_clr(stat_clr), .stat_vid(stat_vid), .stat_dma(stat_dma), .stat_cpu(stat_cpu),
`endif
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_ack(dma_ack),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din), .sd_dout(sd_dout)
    );

    sdram_slot_arbiter #(.LAT(14), .MAX_STARVE(3)) dut14 (
        .clk_sys(clk_sys), .reset_n(reset_n), .clkref(clkref),
`ifdef ARB_STATS_EN
        .stat_clr(stat_clr), .stat_vid(l_stat_vid), .stat_dma(l_stat_dma), .stat_cpu(l_stat_cpu),
`endif
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(l_vid_ack), .vid_data(l_vid_data),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_ack(l_dma_ack),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(l_cpu_ack), .cpu_dout(l_cpu_dout),
        .sd_oe(l_sd_oe), .sd_we(l_sd_we), .sd_addr(l_sd_addr), .sd_din(l_sd_din), .sd_dout(sd_dout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clkref slot on the LAT=4 instance; reports first ack, its latency and enable activity.
    task automatic run_slot(output logic [2:0] ack_v, output int lat, output int ack_cycles,
                            output logic oe1, output logic we1,
                            output logic [22:0] addr1, output logic [7:0] din1,
                            output int en_cycles);
        @(negedge clk_sys) clkref = 1'b1;
        @(negedge clk_sys) clkref = 1'b0;
        oe1 = sd_oe; we1 = sd_we; addr1 = sd_addr; din1 = sd_din;
        en_cycles = (sd_oe | sd_we) ? 1 : 0;
        ack_v = 3'b000; lat = -1; ack_cycles = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_sys);
            if (sd_oe | sd_we) en_cycles++;
            if (vid_ack | dma_ack | cpu_ack) begin
                ack_cycles++;
                if (lat < 0) begin
                    lat = i;
                    ack_v = {vid_ack, dma_ack, cpu_ack};
                end
            end
        end
    endtask

    logic [2:0]  a_v;
    int          a_lat, a_cyc, en_cyc;
    logic        o1, w1;
    logic [22:0] ad1;
    logic [7:0]  d1;
    int          acc, oe_cnt, l_lat;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; clkref = 1'b0;
        vid_req = 0; dma_req = 0; cpu_rd = 0; cpu_wr = 0;
        vid_addr = '0; dma_addr = '0; cpu_addr = '0;
        dma_din = '0; cpu_din = '0; sd_dout = '0;
`ifdef ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(negedge clk_sys);
        check_eq("rst_outs", {sd_oe, sd_we, vid_ack, dma_ack, cpu_ack}, 0);
        check_eq("rst_data", {sd_addr, sd_din, vid_data, cpu_dout}, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Reset arriving in the middle of WAIT
        cpu_rd = 1; cpu_addr = 23'h000010;
        @(negedge clk_sys) clkref = 1'b1;
        @(negedge clk_sys) clkref = 1'b0;
        @(negedge clk_sys);
        check_eq("midwait_oe", sd_oe, 1);
        #2 reset_n = 1'b0;
        #1 check_eq("rst_async_oe", {sd_oe, sd_we}, 0);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            if (cpu_ack) acc++;
        end
        cpu_rd = 0;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            if (cpu_ack) acc++;
        end
        check_eq("rst_no_ack", acc, 0);

        // Idle slots with no requests
        for (int s = 0; s < 5; s++) begin
            run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
            check_eq($sformatf("idle_en%0d", s), en_cyc, 0);
            check_eq($sformatf("idle_ack%0d", s), a_v, 0);
        end

        // CPU read, odd address -> high byte
        cpu_rd = 1; cpu_addr = 23'h000101; sd_dout = 16'hA55A;
        run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
        cpu_rd = 0;
        check_eq("cpurd_oe", {o1, w1}, 2'b10);
        check_eq("cpurd_addr", ad1, 23'h000101);
        check_eq("cpurd_ack", a_v, 3'b001);
        check_eq("cpurd_lat", a_lat, 5);
        check_eq("cpurd_pulse", a_cyc, 1);
        check_eq("cpurd_en_cyc", en_cyc, 5);
        check_eq("cpurd_dout", cpu_dout, 8'hA5);

        // CPU read, even address -> low byte
        cpu_rd = 1; cpu_addr = 23'h000100; sd_dout = 16'h1234;
        run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
        cpu_rd = 0;
        check_eq("cpurd_even", cpu_dout, 8'h34);
        check_eq("vid_hold0", vid_data, 16'h0000);

        // Priority video > DMA > CPU
        vid_req = 1; vid_addr = 23'h0ABCDE;
        dma_req = 1; dma_addr = 23'h012345; dma_din = 8'h5C;
        cpu_wr = 1; cpu_addr = 23'h000777; cpu_din = 8'hC3;
        sd_dout = 16'hBEEF;
        run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
        vid_req = 0;
        check_eq("pri1_ack", a_v, 3'b100);
        check_eq("pri1_oe", {o1, w1}, 2'b10);
        check_eq("pri1_addr", ad1, 23'h0ABCDE);
        check_eq("pri1_data", vid_data, 16'hBEEF);
        run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
        dma_req = 0;
        check_eq("pri2_ack", a_v, 3'b010);
        check_eq("pri2_we", {o1, w1}, 2'b01);
        check_eq("pri2_addr", ad1, 23'h012345);
        check_eq("pri2_din", d1, 8'h5C);
        check_eq("pri2_lat", a_lat, 5);
        run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
        cpu_wr = 0;
        check_eq("pri3_ack", a_v, 3'b001);
        check_eq("pri3_we", {o1, w1}, 2'b01);
        check_eq("pri3_din", d1, 8'hC3);
        check_eq("pri3_addr", ad1, 23'h000777);
        check_eq("wr_keeps_dout", cpu_dout, 8'h34);

        // rd and wr together behave as a write
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 23'h000005; cpu_din = 8'h7E;
        run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
        cpu_rd = 0; cpu_wr = 0;
        check_eq("rdwr_we", {o1, w1}, 2'b01);
        check_eq("rdwr_din", d1, 8'h7E);

        // Starvation guard
        vid_req = 1; vid_addr = 23'h000040;
        cpu_rd = 1; cpu_addr = 23'h000002; sd_dout = 16'h9966;
        for (int s = 1; s <= 5; s++) begin
            run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
            check_eq($sformatf("starve_slot%0d", s), a_v, (s == 4) ? 3'b001 : 3'b100);
        end
        vid_req = 0; cpu_rd = 0;
        check_eq("starve_dout", cpu_dout, 8'h66);

        // Missed slot on the LAT=14 instance
        repeat (20) @(negedge clk_sys);
        cpu_rd = 1; cpu_addr = 23'h000003; sd_dout = 16'h7788;
        @(negedge clk_sys) clkref = 1'b1;
        @(negedge clk_sys) clkref = 1'b0;
        oe_cnt = l_sd_oe ? 1 : 0;
        acc = 0; l_lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_sys);
            if (l_sd_oe) oe_cnt++;
            if (l_cpu_ack) begin
                acc++;
                if (l_lat < 0) l_lat = i;
            end
            if (i == 4) clkref = 1'b1;
            if (i == 5) clkref = 1'b0;
        end
        check_eq("miss_oe_cycles", oe_cnt, 15);
        check_eq("miss_ack_count", acc, 1);
        check_eq("miss_lat", l_lat, 15);
        check_eq("miss_dout", l_cpu_dout, 8'h77);
        sd_dout = 16'h1122; cpu_addr = 23'h000004;
        @(negedge clk_sys) clkref = 1'b1;
        @(negedge clk_sys) clkref = 1'b0;
        check_eq("miss_next_oe", l_sd_oe, 1);
        check_eq("miss_next_addr", l_sd_addr, 23'h000004);
        acc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_sys);
            if (l_cpu_ack) acc++;
        end
        cpu_rd = 0;
        check_eq("miss_next_ack", acc, 1);
        check_eq("miss_next_dout", l_cpu_dout, 8'h22);

`ifdef ARB_STATS_EN
        repeat (20) @(negedge clk_sys);
        stat_clr = 1'b1;
        @(negedge clk_sys) stat_clr = 1'b0;
        check_eq("stat_clr0", {stat_vid, stat_dma, stat_cpu}, 0);
        vid_req = 1;
        for (int s = 0; s < 10; s++) run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
        vid_req = 0; cpu_rd = 1;
        for (int s = 0; s < 2; s++) run_slot(a_v, a_lat, a_cyc, o1, w1, ad1, d1, en_cyc);
        cpu_rd = 0;
        check_eq("stat_vid", stat_vid, 16'd10);
        check_eq("stat_cpu", stat_cpu, 16'd2);
        check_eq("stat_dma", stat_dma, 16'd0);
        stat_clr = 1'b1;
        @(negedge clk_sys) stat_clr = 1'b0;
        check_eq("stat_clr1", {stat_vid, stat_dma, stat_cpu}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_slot_arbiter.md
Name: sdram_slot_arbiter

Overview:
- Shares the single-port SDRAM controller between three requesters: video fetch, boot/ROM download DMA and Z80 CPU.
- Sits between the motherboard/loader logic and the sdram block.
- Grants at most one access per clkref slot and returns read data with a one-cycle ack pulse.
- Priority is video > DMA > CPU, with a CPU starvation guard.

Parameters:
- LAT, 4, clk_sys cycles from a slot issue to SDRAM read data valid (range 2..14).
- MAX_STARVE, 3, consecutive slots a waiting CPU may be denied before it is forced to win.

Ports:
- clk_sys  in  1  system clock (64 MHz)
- reset_n  in  1  asynchronous active-low reset
- clkref  in  1  slot strobe, one-cycle pulse every 16 clk_sys
- vid_req  in  1  video read request, level, held until vid_ack
- vid_addr  in  23  video word address
- vid_ack  out  1  one-cycle pulse, vid_data valid
- vid_data  out  16  video read data
- dma_req  in  1  DMA write request, level
- dma_addr  in  23  DMA address
- dma_din  in  8  DMA write data
- dma_ack  out  1  one-cycle pulse, write accepted
- cpu_rd  in  1  CPU read request, level
- cpu_wr  in  1  CPU write request, level
- cpu_addr  in  23  CPU address
- cpu_din  in  8  CPU write data
- cpu_ack  out  1  one-cycle pulse, cycle complete
- cpu_dout  out  8  CPU read data
- sd_oe  out  1  SDRAM read enable for the current slot
- sd_we  out  1  SDRAM write enable for the current slot
- sd_addr  out  23  SDRAM address
- sd_din  out  8  SDRAM write data
- sd_dout  in  16  SDRAM read data

Behaviour:
- Reset (async, reset_n low):
  - all outputs 0; state IDLE; starve counter 0.
  - Reset mid-slot aborts the slot: sd_oe/sd_we drop immediately, no ack is produced.
- States and transitions:
  - IDLE: on clkref, sample the requests and pick a winner; go to ISSUE. With no request, stay in IDLE.
  - ISSUE (1 cycle): drive sd_oe or sd_we, sd_addr and sd_din from the winner. Go to WAIT with counter = LAT-1.
  - WAIT: sd_oe/sd_we stay asserted and sd_addr/sd_din stay stable. Decrement the counter; at 0 go to DONE.
  - DONE (1 cycle): capture sd_dout. Pulse the winner's ack. Deassert sd_oe/sd_we. Return to IDLE.
- Slot timing:
  - Ack occurs exactly LAT+1 cycles after the clkref that started the slot.
  - A clkref arriving while not in IDLE is ignored; the slot is lost and is not queued.
- Arbitration order at clkref:
  - cpu forced (starve counter == MAX_STARVE and cpu_rd|cpu_wr)
  - then vid_req
  - then dma_req
  - then cpu_rd|cpu_wr.
- Starve counter:
  - Increments (saturating at MAX_STARVE) on each arbitration where the CPU requests and loses.
  - Cleared when the CPU wins, and whenever the CPU is not requesting.
- CPU address and data:
  - cpu_dout = cpu_addr[0] ? sd_dout[15:8] : sd_dout[7:0], selected by the address latched at issue.
  - cpu_rd and cpu_wr both high: treated as a write.
- Write handling:
  - Video is always a read.
  - DMA is always a write; sd_din = dma_din.
- Data holding:
  - vid_data and cpu_dout hold their last captured value until the next read ack of the same requester.
  - Write acks do not alter cpu_dout.
- Request sampling:
  - Requests are sampled only at clkref; address and data are latched at ISSUE.
  - A requester deasserting before its ack still receives the ack.
  - Same-cycle ack and new request: the request is considered at the next clkref.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - adds outputs stat_vid, stat_dma, stat_cpu, 16 bits each. Each counts granted slots for its requester, saturates at 16'hFFFF, and is cleared by reset_n.
  - adds input stat_clr, 1 bit, synchronous clear of all three counters. If stat_clr and a grant occur in the same cycle, the clear takes priority.
- Undefined: these ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset and idle: reset_n low mid-WAIT with cpu_rd=1 -> sd_oe=0 immediately, no cpu_ack; after release with no requests, 5 clkref pulses -> sd_oe=sd_we=0 throughout.
- CPU read latency: LAT=4, cpu_rd=1, cpu_addr=23'h000101, sd_dout=16'hA55A -> sd_oe at clkref+1, cpu_ack exactly 5 cycles after clkref, cpu_dout=8'hA5.
- Priority: vid_req, dma_req and cpu_wr all high at one clkref -> video granted (vid_ack, vid_data=sd_dout); next clkref grants DMA (sd_we=1, sd_din=dma_din); the third grants CPU.
- Starvation: vid_req held high continuously, cpu_rd high, MAX_STARVE=3 -> slots 1..3 go to video, slot 4 to the CPU (cpu_ack), slot 5 back to video.
- Missed slot: clkref pulsed while in WAIT (LAT=14) -> ignored, no second issue; the next clkref in IDLE grants normally.
- Stats (ARB_STATS_EN): 10 video and 2 CPU grants -> stat_vid=10, stat_cpu=2, stat_dma=0; stat_clr pulse -> all 0.
